// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into padded 512-bit blocks.
// Optional raw pass-through for pre-padded messages: define SHA256_PADDER_RAW_EN.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [31:0]  in_data_i,
  input  logic [2:0]   in_bytes_i,
  input  logic         in_last_i,
  input  logic         in_valid_i,
`ifdef SHA256_PADDER_RAW_EN
  input  logic         raw_i,
`endif
  output logic         in_ready_o,
  output logic [511:0] blk_o,
  output logic         blk_first_o,
  output logic         blk_last_o,
  output logic         blk_valid_o,
  input  logic         blk_ready_i
);

  localparam int unsigned WORDS  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT_DATA  = 2'd1,
    EMIT_OVF   = 2'd2,
    EMIT_FINAL = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]    len_q, len_d, len_inc;
  logic                first_q, first_d;
  logic                p64_q, p64_d;
  logic [WORD_W-1:0]   blk_buf_q [WORDS];
  logic [WORD_W-1:0]   blk_buf_d [WORDS];
  logic                valid_q, valid_d;
  logic                first_out_q, first_out_d;
  logic                last_q, last_d;
  logic                ready_q, ready_d;

  logic                accept;
  logic                raw_c;
  logic [2:0]          nb_c;
  logic [6:0]          pos_c;
  logic [63:0]         len_inc_ext;
  logic [63:0]         len_cur_ext;
  logic [WORD_W-1:0]   pad_word;

`ifdef SHA256_PADDER_RAW_EN
  assign raw_c = raw_i;
`else
  assign raw_c = 1'b0;
`endif

  // Next-state, buffer update and registered-output decode
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    len_d       = len_q;
    first_d     = first_q;
    p64_d       = p64_q;
    blk_buf_d   = blk_buf_q;
    accept      = 1'b0;
    pad_word    = '0;

    nb_c        = (!in_last_i || in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
    len_inc     = len_q + (LEN_W'(nb_c) << 3);
    len_inc_ext = 64'(len_inc);
    len_cur_ext = 64'(len_q);
    pos_c       = {1'b0, wr_idx_q, 2'b00} + 7'(nb_c);

    // Keep valid bytes, then the 0x80 marker, then zeros
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < nb_c) begin
        pad_word[31-8*j -: 8] = in_data_i[31-8*j -: 8];
      end else if (3'(j) == nb_c) begin
        pad_word[31-8*j -: 8] = 8'h80;
      end
    end

    case (state_q)
      FILL: begin
        if (in_valid_i && ready_q) begin
          accept   = 1'b1;
          wr_idx_d = wr_idx_q + 4'd1;
          len_d    = len_inc;
          if (!in_last_i) begin
            blk_buf_d[wr_idx_q] = in_data_i;
            if (wr_idx_q == 4'd15) begin
              state_d = EMIT_DATA;
            end
          end else if (raw_c) begin
            for (int i = 0; i < WORDS; i++) begin
              if (4'(i) == wr_idx_q) begin
                blk_buf_d[i] = in_data_i;
              end else if (4'(i) > wr_idx_q) begin
                blk_buf_d[i] = '0;
              end
            end
            state_d = EMIT_FINAL;
          end else begin
            for (int i = 0; i < WORDS; i++) begin
              if (4'(i) == wr_idx_q) begin
                blk_buf_d[i] = pad_word;
              end else if (4'(i) > wr_idx_q) begin
                blk_buf_d[i] = (nb_c == 3'd4 && 5'(i) == 5'(wr_idx_q) + 5'd1) ?
                               32'h8000_0000 : '0;
              end
            end
            if (pos_c <= 7'd55) begin
              blk_buf_d[14] = len_inc_ext[63:32];
              blk_buf_d[15] = len_inc_ext[31:0];
              state_d       = EMIT_FINAL;
            end else begin
              p64_d   = (pos_c == 7'd64);
              state_d = EMIT_OVF;
            end
          end
        end
      end
      EMIT_DATA: begin
        if (blk_ready_i) begin
          state_d  = FILL;
          wr_idx_d = '0;
          first_d  = 1'b0;
        end
      end
      EMIT_OVF: begin
        // Marker spilled past the block (p = 64) lands at the head of the length block
        if (blk_ready_i) begin
          state_d = EMIT_FINAL;
          first_d = 1'b0;
          for (int i = 0; i < WORDS; i++) begin
            blk_buf_d[i] = '0;
          end
          blk_buf_d[0]  = p64_q ? 32'h8000_0000 : 32'h0;
          blk_buf_d[14] = len_cur_ext[63:32];
          blk_buf_d[15] = len_cur_ext[31:0];
        end
      end
      EMIT_FINAL: begin
        if (blk_ready_i) begin
          state_d  = FILL;
          wr_idx_d = '0;
          len_d    = '0;
          first_d  = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    valid_d     = (state_d != FILL);
    first_out_d = valid_d && first_d;
    last_d      = (state_d == EMIT_FINAL);
    ready_d     = (state_d == FILL);
  end

  // State and datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      len_q       <= '0;
      first_q     <= 1'b1;
      p64_q       <= 1'b0;
      valid_q     <= 1'b0;
      first_out_q <= 1'b0;
      last_q      <= 1'b0;
      ready_q     <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        blk_buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      len_q       <= len_d;
      first_q     <= first_d;
      p64_q       <= p64_d;
      valid_q     <= valid_d;
      first_out_q <= first_out_d;
      last_q      <= last_d;
      ready_q     <= ready_d;
      blk_buf_q   <= blk_buf_d;
    end
  end

  always_comb begin
    blk_o = '0;
    for (int i = 0; i < WORDS; i++) begin
      blk_o[511-32*i -: 32] = blk_buf_q[i];
    end
  end

  assign in_ready_o  = ready_q;
  assign blk_valid_o = valid_q;
  assign blk_first_o = first_out_q;
  assign blk_last_o  = last_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic [31:0]  in_data_i = '0;
  logic [2:0]   in_bytes_i = '0;
  logic         in_last_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [511:0] blk_o;
  logic         blk_first_o;
  logic         blk_last_o;
  logic         blk_valid_o;
  logic         blk_ready_i = 1'b0;
`ifdef SHA256_PADDER_RAW_EN
  logic         raw_i = 1'b0;
`endif

  sha256_msg_padder #(.LEN_W(64)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .in_data_i   (in_data_i),
    .in_bytes_i  (in_bytes_i),
    .in_last_i   (in_last_i),
    .in_valid_i  (in_valid_i),
`ifdef SHA256_PADDER_RAW_EN
    .raw_i       (raw_i),
`endif
    .in_ready_o  (in_ready_o),
    .blk_o       (blk_o),
    .blk_first_o (blk_first_o),
    .blk_last_o  (blk_last_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic [7:0]   msg [$];
  logic [511:0] exp_blk [$];
  logic         exp_first [$];
  logic         exp_last [$];

  logic         hold_rdy = 1'b0;
  logic         pending = 1'b0;
  logic [511:0] sav_blk;
  logic         sav_first, sav_last;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: pad the byte string, split into 64-byte blocks
  task automatic model_push();
    logic [7:0]   p [$];
    logic [63:0]  bl;
    logic [511:0] b;
    int           nb;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
      exp_blk.push_back(b);
      exp_first.push_back(k == 0);
      exp_last.push_back(k == nb - 1);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l);
    int t = 0;
    @(negedge wb_clk_i);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_bytes_i = b;
    in_last_i  = l;
    while (!in_ready_o && t < 1000) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (t >= 1000) check("in_ready_timeout", 1'b0, 1'b1);
    @(posedge wb_clk_i);
    #1;
    in_valid_i = 1'b0;
    in_data_i  = $urandom;
    in_bytes_i = 3'($urandom);
    in_last_i  = 1'($urandom);
  endtask

  task automatic drive_msg();
    int          n, words, idx, rem;
    logic [31:0] w;
    logic [2:0]  b;
    logic        l;
    n     = msg.size();
    words = (n == 0) ? 1 : (n + 3) / 4;
    for (int k = 0; k < words; k++) begin
      for (int j = 0; j < 4; j++) begin
        idx = 4 * k + j;
        w[31-8*j -: 8] = (idx < n) ? msg[idx] : 8'($urandom);
      end
      l = (k == words - 1);
      if (l) begin
        rem = n - 4 * k;
        b   = 3'(rem);
        if (rem == 4 && $urandom_range(0, 2) == 0) b = 3'($urandom_range(5, 7));
      end else begin
        b = 3'($urandom);
      end
      send_word(w, b, l);
      repeat ($urandom_range(0, 1)) @(negedge wb_clk_i);
    end
  endtask

  task automatic rand_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  // Output side: random backpressure, stability while stalled, scoreboard on transfer
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      blk_ready_i = 1'b0;
      pending     = 1'b0;
    end else begin
      if (pending) begin
        check("hold_valid", blk_valid_o, 1'b1);
        check("hold_blk", blk_o, sav_blk);
        check("hold_first", blk_first_o, sav_first);
        check("hold_last", blk_last_o, sav_last);
      end
      if (blk_valid_o) begin
        check("ready_while_busy", in_ready_o, 1'b0);
        blk_ready_i = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (exp_blk.size() == 0) begin
          check("spurious_valid", blk_valid_o, 1'b0);
          pending = 1'b0;
        end else if (blk_ready_i) begin
          check("blk", blk_o, exp_blk.pop_front());
          check("first", blk_first_o, exp_first.pop_front());
          check("last", blk_last_o, exp_last.pop_front());
          pending = 1'b0;
        end else begin
          pending   = 1'b1;
          sav_blk   = blk_o;
          sav_first = blk_first_o;
          sav_last  = blk_last_o;
        end
      end else begin
        blk_ready_i = 1'($urandom);
        pending     = 1'b0;
      end
    end
  end

  int lens [15] = '{0, 1, 3, 4, 52, 55, 56, 57, 60, 63, 64, 65, 119, 120, 128};

  initial begin
    int t;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_valid", blk_valid_o, 1'b0);
    check("rst_first", blk_first_o, 1'b0);
    check("rst_last", blk_last_o, 1'b0);
    check("rst_blk", blk_o, 512'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    check("post_rst_in_ready", in_ready_o, 1'b1);

    // "abc" and empty message
    msg = '{8'h61, 8'h62, 8'h63};
    model_push();
    drive_msg();
    msg.delete();
    model_push();
    drive_msg();

    foreach (lens[i]) begin
      rand_msg(lens[i]);
      model_push();
      drive_msg();
    end

    // Backpressure: first message's block stalls while the next message is offered
    hold_rdy = 1'b1;
    fork
      begin
        rand_msg(20);
        model_push();
        drive_msg();
        rand_msg(9);
        model_push();
        drive_msg();
      end
      begin
        t = 0;
        while (!blk_valid_o && t < 2000) begin
          @(negedge wb_clk_i);
          t++;
        end
        if (t >= 2000) check("bp_valid_timeout", 1'b0, 1'b1);
        repeat (5) @(negedge wb_clk_i);
        #1;
        hold_rdy = 1'b0;
      end
    join

    t = 0;
    while (exp_blk.size() != 0 && t < 2000) begin
      @(negedge wb_clk_i);
      t++;
    end
    check("drain_before_reset", 32'(exp_blk.size()), 32'd0);

    // Reset mid-message discards the partial block
    for (int k = 0; k < 7; k++) send_word($urandom, 3'd4, 1'b0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check("mid_rst_valid", blk_valid_o, 1'b0);
    msg = '{8'h61, 8'h62, 8'h63};
    model_push();
    drive_msg();

    for (int r = 0; r < 25; r++) begin
      rand_msg($urandom_range(0, 150));
      model_push();
      drive_msg();
    end

    t = 0;
    while (exp_blk.size() != 0 && t < 5000) begin
      @(negedge wb_clk_i);
      t++;
    end
    check("drain_final", 32'(exp_blk.size()), 32'd0);
    repeat (5) @(negedge wb_clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
